// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if: shared AXI4-Lite types and the AW/W/B/AR/R channel bundle.
package axi_lite_pkg;
   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [1:0]  resp_t;
endpackage

interface axi_lite_if;
   import axi_lite_pkg::*;
   logic  awvalid, awready, wvalid, wready, bvalid, bready;
   logic  arvalid, arready, rvalid, rready;
   addr_t awaddr, araddr;
   data_t wdata, rdata;
   resp_t bresp, rresp;
   modport master (
      output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport slave (
      input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: one-at-a-time AXI4-Lite initiator with a valid/ready response port and error counter.
module axi_lite_master
   import axi_lite_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   axi_lite_if.master  m_axi_lite,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  addr_t       cmd_addr,
   input  data_t       cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output data_t       rsp_rdata,
   output resp_t       rsp_resp,
   output logic [15:0] err_cnt
);
   localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, RESP = 2'd3;
   logic [1:0] state;
   logic       aw_done, w_done;
   assign cmd_ready = state == IDLE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state              <= IDLE;
         aw_done            <= 1'b0;
         w_done             <= 1'b0;
         m_axi_lite.awvalid <= 1'b0;
         m_axi_lite.wvalid  <= 1'b0;
         m_axi_lite.bready  <= 1'b0;
         m_axi_lite.arvalid <= 1'b0;
         m_axi_lite.rready  <= 1'b0;
         m_axi_lite.awaddr  <= '0;
         m_axi_lite.wdata   <= '0;
         m_axi_lite.araddr  <= '0;
         rsp_valid          <= 1'b0;
         rsp_write          <= 1'b0;
         rsp_rdata          <= '0;
         rsp_resp           <= '0;
         err_cnt            <= '0;
      end else
         case (state)
            IDLE: if (cmd_valid) begin
               aw_done          <= 1'b0;
               w_done           <= 1'b0;
               m_axi_lite.wdata <= cmd_wdata;
               if (cmd_write) begin
                  m_axi_lite.awaddr  <= cmd_addr;
                  m_axi_lite.awvalid <= 1'b1;
                  m_axi_lite.wvalid  <= 1'b1;
                  m_axi_lite.bready  <= 1'b1;
                  state              <= WRITE;
               end else begin
                  m_axi_lite.araddr  <= cmd_addr;
                  m_axi_lite.arvalid <= 1'b1;
                  m_axi_lite.rready  <= 1'b1;
                  state              <= READ;
               end
            end
            WRITE: begin
               if (m_axi_lite.awvalid && m_axi_lite.awready) begin
                  m_axi_lite.awvalid <= 1'b0;
                  aw_done            <= 1'b1;
               end
               if (m_axi_lite.wvalid && m_axi_lite.wready) begin
                  m_axi_lite.wvalid <= 1'b0;
                  w_done            <= 1'b1;
               end
               if (m_axi_lite.bvalid) begin
                  m_axi_lite.awvalid <= 1'b0;
                  m_axi_lite.wvalid  <= 1'b0;
                  m_axi_lite.bready  <= 1'b0;
                  rsp_resp           <= m_axi_lite.bresp;
                  rsp_write          <= 1'b1;
                  rsp_rdata          <= '0;
                  rsp_valid          <= 1'b1;
                  err_cnt            <= err_cnt + {15'd0, m_axi_lite.bresp != 2'b00 && err_cnt != 16'hFFFF};
                  state              <= RESP;
               end
            end
            READ: begin
               if (m_axi_lite.arvalid && m_axi_lite.arready) m_axi_lite.arvalid <= 1'b0;
               if (m_axi_lite.rvalid) begin
                  m_axi_lite.arvalid <= 1'b0;
                  m_axi_lite.rready  <= 1'b0;
                  rsp_resp           <= m_axi_lite.rresp;
                  rsp_rdata          <= m_axi_lite.rdata;
                  rsp_write          <= 1'b0;
                  rsp_valid          <= 1'b1;
                  err_cnt            <= err_cnt + {15'd0, m_axi_lite.rresp != 2'b00 && err_cnt != 16'hFFFF};
                  state              <= RESP;
               end
            end
            default: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single-beat read/write commands from local control logic into AXI4-Lite transactions on an `axi_lite_if.master` port. It is the counterpart of the team's AXI4-Lite slave and sits between a register-access sequencer (or CPU bridge) and the interconnect. It issues one transaction at a time and returns the read data and response through a valid/ready response port. It also counts error responses.

## Interface
- Parameters: none. Widths come from the shared `addr_t`, `data_t` and `resp_t` types.
- clk  input  1  clock; all logic is on the rising edge
- rst  input  1  asynchronous, active-low reset
- m_axi_lite  interface  -  `axi_lite_if.master` (AW, W, B, AR, R channels)
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high together with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  addr_t  transaction address
- cmd_wdata  input  data_t  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when high together with rsp_valid
- rsp_write  output  1  response belongs to a write
- rsp_rdata  output  data_t  read data (0 for writes)
- rsp_resp  output  resp_t  BRESP or RRESP captured from the bus
- err_cnt  output  16  saturating count of responses with resp != OKAY (2'b00)

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - cmd_ready = 1; it is combinational from the state and is 0 in every other state.
  - On cmd_valid && cmd_ready:
    - Latch cmd_addr into awaddr or araddr, and cmd_wdata into wdata.
    - Clear the aw_done and w_done flags.
    - Go to WRITE (cmd_write = 1) or READ (cmd_write = 0).
- WRITE:
  - awvalid is held high until the AW handshake, then driven low and aw_done is set.
  - wvalid is handled the same way, independently, setting w_done. AW and W may complete in either order or in the same cycle.
  - bready = 1 for the whole state.
  - On bvalid && bready:
    - Capture bresp into rsp_resp.
    - Set rsp_write = 1 and rsp_rdata = 0.
    - Go to RESP.
  - A B handshake is only legal after aw_done and w_done; the bench flags B accepted earlier as an error.
- READ:
  - arvalid is held high until the AR handshake, then driven low.
  - rready = 1 for the whole state.
  - On rvalid && rready:
    - Capture rdata and rresp.
    - Set rsp_write = 0.
    - Go to RESP.
  - An R beat that arrives in the same cycle as, or after, the AR handshake is accepted.
- RESP:
  - rsp_valid = 1, and rsp_* are held stable.
  - On rsp_ready, go to IDLE.
  - If rsp_resp != 2'b00, err_cnt increments once on the cycle RESP is entered; it saturates at 16'hFFFF.
- awaddr, wdata and araddr stay stable while their valid is high (AXI rule: valid is never withdrawn before ready).

## Timing
- Reset values:
  - awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write = 0.
  - awaddr, wdata, araddr, rsp_rdata, rsp_resp = 0.
  - err_cnt = 0, state = IDLE.
  - cmd_ready = 1 as soon as rst is deasserted.
- All AXI outputs and rsp_* are registered. Only cmd_ready is combinational.
- Command accepted at edge N:
  - awvalid/wvalid or arvalid are high from cycle N+1.
  - bready/rready are high from N+1.
- With a slave that gives awready = wready in cycle N+1 and bvalid in N+2:
  - B handshake at the end of N+2.
  - rsp_valid high in N+3.
  - If rsp_ready is already high, cmd_ready is high again in N+4. Minimum 4 cycles per write.
- Read with arready and rvalid both in cycle N+1: rsp_valid in N+2, the 3-cycle minimum.
- Back-pressure: rsp_ready low holds RESP indefinitely. No new command is accepted and no AXI valid is raised.
- Reset asserted mid-transaction:
  - All valids and readies drop asynchronously.
  - The outstanding transaction is abandoned and err_cnt clears.

## Test plan
- Write, zero-wait slave: cmd addr 0x10, wdata 0xDEADBEEF, bresp OKAY -> AW/W seen with those values in N+1, rsp_valid in N+3 with rsp_write = 1, rsp_resp = 0, err_cnt = 0.
- Skewed write: awready 3 cycles after awvalid, wready in the first cycle -> wvalid drops after 1 cycle, awvalid after 3, awaddr/wdata stable throughout, exactly one response.
- Read: araddr 0x24, slave returns rdata 0x12345678 two cycles after the AR handshake -> rsp_rdata = 0x12345678, rsp_write = 0.
- Error response: read with rresp SLVERR (2'b10) -> rsp_resp = 2'b10, err_cnt becomes 1. Preload the counter to 0xFFFF via a forced error sequence -> it stays 0xFFFF.
- Response back-pressure: rsp_ready low for 5 cycles while cmd_valid is held -> cmd_ready stays 0, no AXI valids. Release -> next command accepted the following cycle.
- Reset mid-write: drop rst while awvalid = 1 -> all outputs return to reset values immediately. After release, a new read completes normally.
